// File: rtl/relax_osc_pkg.sv
// Shared state encoding and default sizing for the relaxation-oscillator calibration sequencer.
package relax_osc_pkg;

    localparam int unsigned TRIM_W_DEF     = 4;
    localparam int unsigned CNT_W_DEF      = 12;
    localparam int unsigned GATE_CYC_DEF   = 256;
    localparam int unsigned SETTLE_CYC_DEF = 16;
    localparam int unsigned TRIM_RST_DEF   = 1 << (TRIM_W_DEF - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        DECIDE,
        DONE
    } state_t;

endpackage

// File: rtl/relax_osc_edge_counter.sv
// Synchronises the free-running oscillator into clk, detects rising edges and counts them
// with saturation while enabled.
module relax_osc_edge_counter
    import relax_osc_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_in,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // [0],[1] form the two-flop synchroniser, [2] holds the previous synchronised level
    logic [2:0] sync_q;
    logic       rise_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], osc_in};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && rise_c && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/relax_osc_cal_ctrl.sv
// Calibration sequencer: SAR search for the highest oscillator trim whose edge count per gate
// stays at or below the target.
module relax_osc_cal_ctrl
    import relax_osc_pkg::*;
#(
    parameter int unsigned TRIM_W     = TRIM_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned GATE_CYC   = GATE_CYC_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned TRIM_RST   = 1 << (TRIM_W - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  target,
    input  logic              osc_in,
    output logic              osc_en,
    output logic [TRIM_W-1:0] trim,
    output logic [CNT_W-1:0]  meas_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMR_W = $clog2((GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC);
    localparam int unsigned IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] TRIM_INIT = TRIM_W'(TRIM_RST);
    localparam logic [TRIM_W-1:0] TRIAL_MSB = TRIM_W'(1) << (TRIM_W - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]  GATE_LAST   = TMR_W'(GATE_CYC - 1);

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [IDX_W-1:0]  idx;
    logic [TRIM_W-1:0] saved_trim;
    logic [TRIM_W-1:0] decide_trim_c;
    logic              cal_ok;
    logic [CNT_W-1:0]  count;
    logic              clear_c;
    logic              enable_c;

    assign clear_c  = (state == SETTLE);
    assign enable_c = (state == MEASURE);

    relax_osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .clear  (clear_c),
        .enable (enable_c),
        .count  (count)
    );

    // Resolve the bit under test and arm the next lower bit as the following trial
    always_comb begin
        decide_trim_c = trim;
        if (count > target) begin
            decide_trim_c[idx] = 1'b0;
        end
        if (idx != '0) begin
            decide_trim_c[idx - IDX_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            trim       <= TRIM_INIT;
            saved_trim <= TRIM_INIT;
            osc_en     <= 1'b0;
            meas_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cal_ok     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state inside {SETTLE, MEASURE, DECIDE})) begin
                // Back out to the pre-calibration trim; keep the oscillator up if it was trusted
                state  <= IDLE;
                trim   <= saved_trim;
                osc_en <= cal_ok;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state      <= SETTLE;
                            saved_trim <= trim;
                            idx        <= IDX_W'(TRIM_W - 1);
                            trim       <= TRIAL_MSB;
                            osc_en     <= 1'b1;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            timer      <= '0;
                        end
                    end
                    SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            state <= MEASURE;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (timer == GATE_LAST) begin
                            state <= DECIDE;
                            timer <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    DECIDE: begin
                        meas_count <= count;
                        trim       <= decide_trim_c;
                        if (count == '0) begin
                            err <= 1'b1;
                        end
                        if (idx != '0) begin
                            idx   <= idx - IDX_W'(1);
                            state <= SETTLE;
                        end else begin
                            state  <= DONE;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            cal_ok <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
